aplic_msi_scheduler: RTL

- MSI delivery sequencer for the minimal APLIC in MSI mode. Sits between the domain's pending/enable state and the AXI-style MSI write port.
- Picks one eligible source at a time, round-robin, and looks up its target address and EIID through a combinational lookup port.
- Issues a single MSI write, waits for the write response, then clears the source's pending bit.

---
 rtl/aplic_msi_scheduler_if.sv | 36 +++
 rtl/aplic_msi_scheduler.sv | 116 +++++++++++
 2 files changed

// File: rtl/aplic_msi_scheduler_if.sv
// MSI write channel between the APLIC delivery sequencer and the AXI-style write port.
// One request beat (valid/ready, addr, data) and one response beat (bvalid/bready, bresp).
interface aplic_msi_scheduler_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 32
);

  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              bvalid;
  logic [1:0]        bresp;
  logic              bready;

  modport master (
    output valid,
    output addr,
    output data,
    output bready,
    input  ready,
    input  bvalid,
    input  bresp
  );

  modport slave (
    input  valid,
    input  addr,
    input  data,
    input  bready,
    output ready,
    output bvalid,
    output bresp
  );

endinterface

// File: rtl/aplic_msi_scheduler.sv
// MSI delivery sequencer: round-robin picks one eligible source, looks up its target,
// issues a single MSI write, waits for the response, then pulses a pending-clear.
module aplic_msi_scheduler #(
  parameter int unsigned NR_SRC = 32,
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 32
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NR_SRC-1:0]         i_pending,
  input  logic [NR_SRC-1:0]         i_enabled,
  input  logic                      i_domain_ie,
  output logic [$clog2(NR_SRC)-1:0] o_lookup_idx,
  input  logic [ADDR_W-1:0]         i_lookup_addr,
  input  logic [10:0]               i_lookup_eiid,
  aplic_msi_scheduler_if.master     msi,
  output logic                      o_clr_pending,
  output logic [$clog2(NR_SRC)-1:0] o_clr_idx,
  output logic                      o_err,
  output logic                      o_busy
);

  localparam int unsigned IDX_W = $clog2(NR_SRC);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_REQ   = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   sel_idx;
  logic [IDX_W-1:0]   last_idx;
  logic [NR_SRC-1:0]  elig;
  logic               any_elig;
  logic [IDX_W-1:0]   pick_idx;
  int unsigned        cand;
  logic [IDX_W-1:0]   cand_idx;

  // Source 0 is reserved and never eligible; IE gates all sources.
  always_comb begin
    elig    = i_pending & i_enabled & {NR_SRC{i_domain_ie}};
    elig[0] = 1'b0;
  end

  // Round-robin search starting just after last_idx; last_idx itself is visited last.
  always_comb begin
    any_elig = 1'b0;
    pick_idx = '0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned off = 1; off <= NR_SRC; off++) begin
      cand = 32'(last_idx) + off;
      if (cand >= NR_SRC) begin
        cand = cand - NR_SRC;
      end
      cand_idx = IDX_W'(cand);
      if (!any_elig && elig[cand_idx]) begin
        any_elig = 1'b1;
        pick_idx = cand_idx;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      sel_idx  <= '0;
      last_idx <= '0;
      msi.addr <= '0;
      msi.data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_elig) begin
            sel_idx <= pick_idx;
            state   <= ST_LATCH;
          end
        end
        // Selection may have gone stale in the cycle since IDLE; abandon silently if so.
        ST_LATCH: begin
          if (elig[sel_idx]) begin
            msi.addr <= i_lookup_addr;
            msi.data <= DATA_W'(i_lookup_eiid);
            state    <= ST_REQ;
          end else begin
            state    <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (msi.ready) begin
            state <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (msi.bvalid) begin
            last_idx <= sel_idx;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Handshake strobes decode straight from the state register so reset drops them at once.
  assign msi.valid     = (state == ST_REQ);
  assign msi.bready    = (state == ST_RESP);
  assign o_busy        = (state != ST_IDLE);
  assign o_lookup_idx  = sel_idx;
  assign o_clr_idx     = sel_idx;
  assign o_clr_pending = (state == ST_RESP) && msi.bvalid;
  assign o_err         = (state == ST_RESP) && msi.bvalid && (msi.bresp != 2'd0);

endmodule
